// File: rtl/sram_pattern_tester.sv
// sram_pattern_tester: two-pass write-all/read-all/compare sweep driving spi_sram_encoder.
// Optional encoder watchdog enabled by defining SRAM_TESTER_TIMEOUT_EN.
module sram_pattern_tester #(
  parameter int                         WORD_WIDTH     = 16,
  parameter int                         ADDRESS_WIDTH  = 16,
  parameter logic [ADDRESS_WIDTH-1:0]   START_ADDR     = '0,
  parameter logic [ADDRESS_WIDTH-1:0]   END_ADDR       = {ADDRESS_WIDTH{1'b1}},
  parameter logic [WORD_WIDTH-1:0]      SEED           = 'h5555,
  parameter int                         TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  output logic                     running,
  output logic                     done,
  output logic                     pass,
  output logic [15:0]              error_count,
  output logic [ADDRESS_WIDTH-1:0] fail_address,
  output logic [WORD_WIDTH-1:0]    fail_expected,
  output logic [WORD_WIDTH-1:0]    fail_actual,
  output logic                     timeout,
  output logic                     sram_request,
  input  logic                     sram_busy,
  input  logic                     sram_initialized,
  output logic [ADDRESS_WIDTH-1:0] sram_address,
  output logic                     sram_write_enable,
  output logic [WORD_WIDTH-1:0]    sram_write_data,
  input  logic [WORD_WIDTH-1:0]    sram_read_data
);
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_INIT = 3'd1;
  localparam logic [2:0] S_WR_REQ    = 3'd2;
  localparam logic [2:0] S_WR_WAIT   = 3'd3;
  localparam logic [2:0] S_RD_REQ    = 3'd4;
  localparam logic [2:0] S_RD_WAIT   = 3'd5;
  localparam logic [2:0] S_NEXT      = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;
  logic [2:0]               state;
  logic                     pass_num;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [WORD_WIDTH-1:0]    pattern, expected;
  logic                     at_end, accept, mismatch, writing, tmo_hit;
  assign pattern           = WORD_WIDTH'(addr) ^ SEED;
  assign expected          = pass_num ? ~pattern : pattern;
  assign at_end            = addr == END_ADDR;
  assign accept            = start && (state == S_IDLE || state == S_DONE);
  assign mismatch          = sram_read_data != expected;
  assign writing           = state == S_WR_REQ || state == S_WR_WAIT;
  assign running           = state != S_IDLE && state != S_DONE;
  assign sram_request      = state == S_WR_REQ || state == S_RD_REQ;
  assign sram_address      = addr;
  assign sram_write_enable = writing;
  assign sram_write_data   = writing ? expected : '0;
  assign pass              = done && error_count == '0 && !timeout;
`ifdef SRAM_TESTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt, tmo_eff;
  logic [2:0]    prev_state;
  logic          active;
  // Counter restarts whenever the FSM lands in a new state.
  assign active  = state inside {S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT};
  assign tmo_eff = state != prev_state ? '0 : tmo_cnt;
  assign tmo_hit = active && tmo_eff == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      prev_state <= S_IDLE;
      tmo_cnt    <= '0;
      timeout    <= 1'b0;
    end else begin
      prev_state <= state;
      tmo_cnt    <= active ? tmo_eff + 1'b1 : '0;
      timeout    <= accept ? 1'b0 : (timeout | tmo_hit);
    end
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state         <= S_IDLE;
      pass_num      <= 1'b0;
      addr          <= '0;
      done          <= 1'b0;
      error_count   <= '0;
      fail_address  <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
    end else if (accept) begin
      state         <= sram_initialized ? S_WR_REQ : S_WAIT_INIT;
      pass_num      <= 1'b0;
      addr          <= START_ADDR;
      done          <= 1'b0;
      error_count   <= '0;
      fail_address  <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
    end else if (tmo_hit) begin
      state <= S_DONE;
      done  <= 1'b1;
    end else begin
      case (state)
        S_WAIT_INIT: if (sram_initialized) state <= S_WR_REQ;
        S_WR_REQ:    if (sram_busy) state <= S_WR_WAIT;
        S_RD_REQ:    if (sram_busy) state <= S_RD_WAIT;
        S_WR_WAIT: if (!sram_busy) begin
          state <= at_end ? S_RD_REQ : S_WR_REQ;
          addr  <= at_end ? START_ADDR : addr + 1'b1;
        end
        S_RD_WAIT: if (!sram_busy) begin
          if (mismatch) begin
            if (error_count == '0) begin
              fail_address  <= addr;
              fail_expected <= expected;
              fail_actual   <= sram_read_data;
            end
            if (error_count != '1) error_count <= error_count + 1'b1;
          end
          state <= at_end ? S_NEXT : S_RD_REQ;
          if (!at_end) addr <= addr + 1'b1;
        end
        S_NEXT: begin
          state    <= pass_num ? S_DONE : S_WR_REQ;
          done     <= pass_num;
          pass_num <= 1'b1;
          addr     <= START_ADDR;
        end
        default: ;
      endcase
    end
endmodule
